// File: rtl/vga_pkg.sv
// vga_pkg: definitions shared by the display-memory writer and the video
// generator's read side.
//   VGA_ADDR_W / VGA_DATA_W : geometry of the 256 x 32-bit display memory
//   wr_state_t              : states of the writer's commit FSM
package vga_pkg;

  localparam int VGA_ADDR_W = 8;
  localparam int VGA_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_BLANK = 2'd1,
    DRAIN      = 2'd2
  } wr_state_t;

endpackage

// File: rtl/vga_mem_writer_sync_fifo.sv
// sync_fifo: single-clock FIFO with show-ahead read data.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   clr          clears pointers and count; wins over push and pop
//   push, din    write din at the tail (ignored when full or clr)
//   pop          advance the head (ignored when empty or clr)
//   full, empty  occupancy flags
//   count        occupied entries, 0..DEPTH
//   dout         entry at the head (valid while !empty)
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 40
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         dout
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_eff;
  logic             pop_eff;

  // Flags, qualified handshakes and next pointer/count values.
  always_comb begin
    full     = (count_q == DEPTH_C);
    empty    = (count_q == {CNT_W{1'b0}});
    push_eff = push && !full && !clr;
    pop_eff  = pop && !empty && !clr;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      // DEPTH is a power of two, so the pointers wrap by plain overflow.
      if (push_eff) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_eff) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_eff, pop_eff})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push_eff) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

endmodule

// File: rtl/vga_mem_writer.sv
// vga_mem_writer: buffers processor stores to the display memory and commits
// them only while the video side is in vertical blanking.
// Ports:
//   clk, rstBtn          clock and synchronous active-high reset
//   wr_valid/wr_ready    store handshake from the core; wr_ready = !full
//   wr_addr, wr_data     display word address and data
//   flush                drop all buffered, uncommitted stores
//   vblank_in            blanking level from the video domain (synchronized here)
//   mem_we/addr/wdata    registered write port of the display RAM
//   fifo_count           buffered entries
//   busy                 FSM not IDLE or entries still buffered
module vga_mem_writer
  import vga_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = VGA_ADDR_W,
  parameter int DATA_W = VGA_DATA_W
) (
  input  logic                     clk,
  input  logic                     rstBtn,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     flush,
  input  logic                     vblank_in,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     busy
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ENT_W = ADDR_W + DATA_W;

  wr_state_t         state_q, state_d;
  logic              vb_meta_q, vb_meta_d;
  logic              vb_sync_q, vb_sync_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [CNT_W-1:0]  fifo_count_s;
  logic [ENT_W-1:0]  fifo_dout_s;
  logic              push_acc_s;
  logic              pop_s;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rstBtn),
    .clr   (flush),
    .push  (wr_valid),
    .pop   (pop_s),
    .din   ({wr_addr, wr_data}),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s),
    .dout  (fifo_dout_s)
  );

  // Next-state logic: synchronizer, commit FSM, pop and output register.
  always_comb begin
    vb_meta_d   = vblank_in;
    vb_sync_d   = vb_meta_q;
    state_d     = state_q;
    pop_s       = 1'b0;
    // A push the FIFO will actually accept this cycle; lets IDLE leave on the
    // push edge itself, which is what gives the 3-cycle store-to-write path.
    push_acc_s  = wr_valid && !fifo_full_s && !flush;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (push_acc_s || !fifo_empty_s) begin
            state_d = WAIT_BLANK;
          end else begin
            state_d = IDLE;
          end
        end
        WAIT_BLANK: begin
          if (vb_sync_q) begin
            state_d = DRAIN;
          end else begin
            state_d = WAIT_BLANK;
          end
        end
        DRAIN: begin
          // Blanking ended: stop without popping; the write registered last
          // cycle is the only one that still reaches the RAM.
          if (!vb_sync_q) begin
            state_d = WAIT_BLANK;
          end else if (fifo_empty_s) begin
            state_d = IDLE;
          end else begin
            pop_s = 1'b1;
            if ((fifo_count_s == CNT_W'(1)) && !push_acc_s) begin
              state_d = IDLE;
            end else begin
              state_d = DRAIN;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    mem_we_d = pop_s;
    if (pop_s) begin
      mem_addr_d  = fifo_dout_s[ENT_W-1:DATA_W];
      mem_wdata_d = fifo_dout_s[DATA_W-1:0];
    end else begin
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
    end
  end

  // State, synchronizer and write-port registers.
  always_ff @(posedge clk) begin
    if (rstBtn) begin
      state_q     <= IDLE;
      vb_meta_q   <= 1'b0;
      vb_sync_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
    end else begin
      state_q     <= state_d;
      vb_meta_q   <= vb_meta_d;
      vb_sync_q   <= vb_sync_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign wr_ready   = !fifo_full_s;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign fifo_count = fifo_count_s;
  assign busy       = (state_q != IDLE) || (fifo_count_s != {CNT_W{1'b0}});

endmodule

// File: tb/tb_vga_mem_writer.sv
// Bench for vga_mem_writer: directed scenarios followed by random traffic,
// checked against a queue model of accepted stores and a vblank history.
module tb_vga_mem_writer;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int ENT_W  = ADDR_W + DATA_W;

  logic                    clk = 1'b0;
  logic                    rstBtn;
  logic                    wr_valid;
  logic                    wr_ready;
  logic [ADDR_W-1:0]       wr_addr;
  logic [DATA_W-1:0]       wr_data;
  logic                    flush;
  logic                    vblank_in;
  logic                    mem_we;
  logic [ADDR_W-1:0]       mem_addr;
  logic [DATA_W-1:0]       mem_wdata;
  logic [$clog2(DEPTH):0]  fifo_count;
  logic                    busy;

  vga_mem_writer #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk        (clk),
    .rstBtn     (rstBtn),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .flush      (flush),
    .vblank_in  (vblank_in),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .fifo_count (fifo_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Model: stores accepted but not yet seen on the RAM port, in order.
  logic [ENT_W-1:0] q[$];
  int               wr_log[$];   // cycle index of every observed write
  logic [2:0]       vb_hist;     // vblank_in of the last three cycles, [2] oldest
  int               cycle;
  int               n_asrt;
  int               n_fail;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: update the model with what was sampled at the edge, then
  // check the outputs half a cycle later.
  task automatic tick();
    logic [ENT_W-1:0] e;
    int               avail;
    @(posedge clk);
    cycle++;
    vb_hist = {vb_hist[1:0], vblank_in};
    if (rstBtn) begin
      q.delete();
      vb_hist = 3'b000;
    end else if (flush) begin
      q.delete();
    end else if (wr_valid && (q.size() < DEPTH)) begin
      q.push_back({wr_addr, wr_data});
    end
    @(negedge clk);
    if (mem_we === 1'b1) begin
      wr_log.push_back(cycle);
      avail = q.size();
      chk("write_has_entry", (avail != 0), 1'b1);
      // A write needs vblank_s high in its pop cycle, i.e. vblank_in high
      // three cycles back through the two synchronizer flops.
      chk("write_in_blank", vb_hist[2], 1'b1);
      if (avail != 0) begin
        e = q.pop_front();
        chk("sb_addr", mem_addr, e[ENT_W-1:DATA_W]);
        chk("sb_data", mem_wdata, e[DATA_W-1:0]);
      end
    end
    chk("fifo_count", fifo_count, q.size());
    chk("wr_ready", wr_ready, (q.size() < DEPTH));
    chk("busy", busy, (q.size() != 0));
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic wait_writes(input string tag, input int n, input int budget);
    int start;
    start = wr_log.size();
    for (int k = 0; k < budget && (wr_log.size() - start) < n; k++) tick();
    chk(tag, ((wr_log.size() - start) >= n), 1'b1);
  endtask

  initial begin
    int push_cyc;
    int rise;
    int idx;
    int vb_len;
    bit seen;
    n_asrt = 0; n_fail = 0; cycle = 0; vb_hist = 3'b000;
    rstBtn = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    flush = 1'b0; vblank_in = 1'b0;

    // Reset values.
    ticks(2);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 8'h00);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_ready", wr_ready, 1'b1);
    rstBtn = 1'b0;
    tick();

    // Single store while already blanking: write 3 cycles after the push.
    vblank_in = 1'b1;
    ticks(3);
    idx = wr_log.size();
    push_cyc = cycle;
    push(8'h10, 32'hDEADBEEF);
    wait_writes("t1_timeout", 1, 10);
    if (wr_log.size() > idx) chk("t1_latency", wr_log[idx], push_cyc + 3);
    tick();
    chk("t1_busy_after", busy, 1'b0);

    // Fill outside blanking, then 8 back-to-back writes 4 cycles after the rise.
    vblank_in = 1'b0;
    ticks(3);
    idx = wr_log.size();
    for (int i = 0; i < 8; i++) push(ADDR_W'(i), DATA_W'(i * 3));
    ticks(3);
    chk("t2_full_ready", wr_ready, 1'b0);
    chk("t2_full_count", fifo_count, 8);
    chk("t2_no_write", wr_log.size(), idx);
    vblank_in = 1'b1;
    rise = cycle;
    wait_writes("t2_timeout", 8, 30);
    for (int i = 0; i < 8; i++)
      if (wr_log.size() > idx + i) chk("t2_write_cycle", wr_log[idx + i], rise + 4 + i);

    // Blanking ends mid-drain: the two pops already past the synchronizer
    // still land, the rest wait for the next blanking period.
    vblank_in = 1'b0;
    ticks(4);
    for (int i = 0; i < 8; i++) push(ADDR_W'(8'h20 + i), $urandom);
    vblank_in = 1'b1;
    idx = wr_log.size();
    wait_writes("t3_first3", 3, 30);
    vblank_in = 1'b0;
    ticks(10);
    chk("t3_writes_before_stop", wr_log.size() - idx, 5);
    chk("t3_kept_count", fifo_count, 3);
    chk("t3_waiting_busy", busy, 1'b1);
    vblank_in = 1'b1;
    wait_writes("t3_rest", 3, 30);
    ticks(5);
    chk("t3_total_writes", wr_log.size() - idx, 8);

    // Full FIFO draining with wr_valid held: count stays in 7..8.
    vblank_in = 1'b0;
    ticks(3);
    for (int i = 0; i < 8; i++) push(ADDR_W'(8'h40 + i), $urandom);
    vblank_in = 1'b1;
    wr_valid = 1'b1;
    idx = wr_log.size();
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      wr_addr = ADDR_W'($urandom);
      wr_data = $urandom;
      tick();
      if (!seen && (wr_log.size() > idx)) begin
        seen = 1'b1;
        chk("t4_ready_after_pop", wr_ready, 1'b1);
      end else if (seen) begin
        chk("t4_count_band", (fifo_count >= 7 && fifo_count <= 8), 1'b1);
      end
    end
    chk("t4_drain_started", seen, 1'b1);
    wr_valid = 1'b0;
    for (int k = 0; k < 40 && q.size() != 0; k++) tick();
    chk("t4_drained", fifo_count, 0);

    // Flush with a simultaneous push discards everything.
    vblank_in = 1'b0;
    ticks(3);
    for (int i = 0; i < 5; i++) push(ADDR_W'(8'h60 + i), $urandom);
    wr_valid = 1'b1; flush = 1'b1;
    wr_addr = 8'h77; wr_data = 32'h1234_5678;
    tick();
    wr_valid = 1'b0; flush = 1'b0;
    chk("t5_count", fifo_count, 0);
    chk("t5_idle", busy, 1'b0);
    idx = wr_log.size();
    vblank_in = 1'b1;
    ticks(10);
    chk("t5_no_write", wr_log.size(), idx);

    // Reset in mid-drain.
    vblank_in = 1'b0;
    ticks(3);
    for (int i = 0; i < 6; i++) push(ADDR_W'(8'h80 + i), $urandom);
    vblank_in = 1'b1;
    wait_writes("t6_started", 2, 30);
    rstBtn = 1'b1;
    tick();
    rstBtn = 1'b0;
    chk("t6_mem_we", mem_we, 1'b0);
    chk("t6_count", fifo_count, 0);
    chk("t6_ready", wr_ready, 1'b1);
    idx = wr_log.size();
    ticks(10);
    chk("t6_no_write", wr_log.size(), idx);

    // Random traffic with random blanking windows and occasional flushes.
    vb_len = 0;
    for (int k = 0; k < 800; k++) begin
      if (vb_len == 0) begin
        vblank_in = ~vblank_in;
        vb_len = $urandom_range(1, 20);
      end
      vb_len--;
      wr_valid = ($urandom_range(0, 2) != 0);
      wr_addr  = ADDR_W'($urandom);
      wr_data  = $urandom;
      flush    = ($urandom_range(0, 59) == 0);
      tick();
    end
    wr_valid = 1'b0; flush = 1'b0; vblank_in = 1'b1;
    for (int k = 0; k < 50 && q.size() != 0; k++) tick();
    ticks(4);
    chk("rand_drained", fifo_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
